// File: rtl/dp2_pkg.sv
// Shared definitions for the DP2 demux: channel count, channel index type and select decode.
package dp2_pkg;

  localparam int NUM_CH = 4;

  typedef logic [1:0] ch_idx_t;

  // S0 is the MSB, matching the select table of the 4x1 MUX.
  function automatic ch_idx_t sel_to_ch(input logic s0, input logic s1);
    return {s0, s1};
  endfunction

endpackage

// File: rtl/demux_chan_buf.sv
// One DEPTH-entry FIFO channel. Occupancy is held in a counter rather than derived from pointers.
module demux_chan_buf #(
  parameter int DATA_W = 1,
  parameter int DEPTH  = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              ready,
  output logic [DATA_W-1:0] head,
  output logic              valid,
  output logic [CW-1:0]     count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] last;
  logic              do_push;
  logic              do_pop;

  assign valid   = (cnt != '0);
  assign count   = cnt;
  assign do_push = push && (cnt < CW'(DEPTH));
  assign do_pop  = valid && ready;

  // Once empty, keep showing the word that was last popped.
  assign head = valid ? mem[rd_ptr] : last;

  always_ff @(posedge clk) begin
    if (do_push && !rst) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      last   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        last   <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/demux_1x4_buf.sv
// Buffered 1-to-4 demux: steers each accepted word into the FIFO picked by {S0,S1}.
// IN_READY depends only on the select and registered occupancy, never on READYn.
module demux_1x4_buf
  import dp2_pkg::*;
#(
  parameter int DATA_W = 1,
  parameter int DEPTH  = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] IN,
  input  logic              S0,
  input  logic              S1,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic [DATA_W-1:0] OUT0,
  output logic [DATA_W-1:0] OUT1,
  output logic [DATA_W-1:0] OUT2,
  output logic [DATA_W-1:0] OUT3,
  output logic              VALID0,
  output logic              VALID1,
  output logic              VALID2,
  output logic              VALID3,
  input  logic              READY0,
  input  logic              READY1,
  input  logic              READY2,
  input  logic              READY3,
  output logic [CW-1:0]     CNT0,
  output logic [CW-1:0]     CNT1,
  output logic [CW-1:0]     CNT2,
  output logic [CW-1:0]     CNT3
);

  ch_idx_t           ch;
  logic              ready_a [NUM_CH];
  logic              valid_a [NUM_CH];
  logic [DATA_W-1:0] out_a   [NUM_CH];
  logic [CW-1:0]     cnt_a   [NUM_CH];

  assign ch       = sel_to_ch(S0, S1);
  assign IN_READY = !RST && (cnt_a[ch] < CW'(DEPTH));

  assign ready_a[0] = READY0;
  assign ready_a[1] = READY1;
  assign ready_a[2] = READY2;
  assign ready_a[3] = READY3;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    demux_chan_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_buf (
      .clk     (CLK),
      .rst     (RST),
      .push    (IN_VALID && IN_READY && (ch == ch_idx_t'(g))),
      .data_in (IN),
      .ready   (ready_a[g]),
      .head    (out_a[g]),
      .valid   (valid_a[g]),
      .count   (cnt_a[g])
    );
  end

  assign OUT0   = out_a[0];
  assign OUT1   = out_a[1];
  assign OUT2   = out_a[2];
  assign OUT3   = out_a[3];
  assign VALID0 = valid_a[0];
  assign VALID1 = valid_a[1];
  assign VALID2 = valid_a[2];
  assign VALID3 = valid_a[3];
  assign CNT0   = cnt_a[0];
  assign CNT1   = cnt_a[1];
  assign CNT2   = cnt_a[2];
  assign CNT3   = cnt_a[3];

endmodule

// File: tb/tb_demux_1x4_buf.sv
// Directed bench for demux_1x4_buf with DATA_W=1, DEPTH=2.
module tb_demux_1x4_buf;

  logic       CLK = 1'b0;
  logic       RST, S0, S1, IN_VALID;
  logic [0:0] IN;
  logic       IN_READY;
  logic [0:0] OUT0, OUT1, OUT2, OUT3;
  logic       VALID0, VALID1, VALID2, VALID3;
  logic       READY0, READY1, READY2, READY3;
  logic [1:0] CNT0, CNT1, CNT2, CNT3;

  int checks = 0;
  int errors = 0;

  logic [3:0] vld;
  logic [3:0] outs;
  assign vld  = {VALID3, VALID2, VALID1, VALID0};
  assign outs = {OUT3, OUT2, OUT1, OUT0};

  always #5 CLK = ~CLK;

  demux_1x4_buf #(.DATA_W(1), .DEPTH(2)) dut (
    .CLK(CLK), .RST(RST), .IN(IN), .S0(S0), .S1(S1),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OUT0(OUT0), .OUT1(OUT1), .OUT2(OUT2), .OUT3(OUT3),
    .VALID0(VALID0), .VALID1(VALID1), .VALID2(VALID2), .VALID3(VALID3),
    .READY0(READY0), .READY1(READY1), .READY2(READY2), .READY3(READY3),
    .CNT0(CNT0), .CNT1(CNT1), .CNT2(CNT2), .CNT3(CNT3)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] sel, input logic d);
    IN_VALID = v;
    {S0, S1} = sel;
    IN = d;
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; READY0 = 1'b1; READY1 = 1'b1; READY2 = 1'b1; READY3 = 1'b1;
    drive(1'b1, 2'b00, 1'b1);
    tick(); tick();
    checks++; if (IN_READY !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", IN_READY); end
    checks++; if (vld !== 4'b0000) begin errors++; $display("FAIL rst_valid got %b want 0000", vld); end
    checks++; if ({CNT3, CNT2, CNT1, CNT0} !== 8'h00) begin errors++; $display("FAIL rst_cnt got %h want 00", {CNT3, CNT2, CNT1, CNT0}); end
    checks++; if (outs !== 4'b0000) begin errors++; $display("FAIL rst_out got %b want 0000", outs); end
    RST = 1'b0;
    drive(1'b0, 2'b00, 1'b0);
    checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL rel_in_ready got %b want 1", IN_READY); end
  endtask

  task automatic test_routing();
    logic [3:0] want;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), 1'b1);
      tick();
      want = 4'b0001 << i;
      checks++; if (vld !== want) begin errors++; $display("FAIL route_valid ch%0d got %b want %b", i, vld, want); end
      checks++; if (outs[i] !== 1'b1) begin errors++; $display("FAIL route_out ch%0d got %b want 1", i, outs[i]); end
    end
    drive(1'b0, 2'b00, 1'b0);
    tick();
    checks++; if (vld !== 4'b0000) begin errors++; $display("FAIL route_drain got %b want 0000", vld); end
  endtask

  task automatic test_backpressure();
    READY2 = 1'b0;
    drive(1'b1, 2'b10, 1'b1); tick();
    drive(1'b1, 2'b10, 1'b0); tick();
    checks++; if (CNT2 !== 2'd2) begin errors++; $display("FAIL bp_full_cnt got %0d want 2", CNT2); end
    drive(1'b1, 2'b10, 1'b1);
    checks++; if (IN_READY !== 1'b0) begin errors++; $display("FAIL bp_full_rdy got %b want 0", IN_READY); end
    tick();
    checks++; if (CNT2 !== 2'd2 || OUT2 !== 1'b1) begin errors++; $display("FAIL bp_hold got cnt=%0d out=%b want cnt=2 out=1", CNT2, OUT2); end
    READY2 = 1'b1;
    tick();
    checks++; if (CNT2 !== 2'd1 || OUT2 !== 1'b0) begin errors++; $display("FAIL bp_pop1 got cnt=%0d out=%b want cnt=1 out=0", CNT2, OUT2); end
    checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL bp_rdy_again got %b want 1", IN_READY); end
    tick();
    checks++; if (CNT2 !== 2'd1 || OUT2 !== 1'b1) begin errors++; $display("FAIL bp_held_word got cnt=%0d out=%b want cnt=1 out=1", CNT2, OUT2); end
    drive(1'b0, 2'b10, 1'b0);
    tick();
    checks++; if (VALID2 !== 1'b0 || CNT2 !== 2'd0 || OUT2 !== 1'b1) begin errors++; $display("FAIL bp_empty got v=%b cnt=%0d out=%b want v=0 cnt=0 out=1", VALID2, CNT2, OUT2); end
  endtask

  task automatic test_simul_push_pop();
    READY1 = 1'b0;
    drive(1'b1, 2'b01, 1'b1); tick();
    READY1 = 1'b1;
    drive(1'b1, 2'b01, 1'b0);
    checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL pp_rdy got %b want 1", IN_READY); end
    tick();
    checks++; if (CNT1 !== 2'd1 || OUT1 !== 1'b0) begin errors++; $display("FAIL pp_cnt_same got cnt=%0d out=%b want cnt=1 out=0", CNT1, OUT1); end
    READY1 = 1'b0;
    drive(1'b1, 2'b01, 1'b1); tick();
    checks++; if (CNT1 !== 2'd2) begin errors++; $display("FAIL pp_fill got %0d want 2", CNT1); end
    READY1 = 1'b1;
    drive(1'b1, 2'b01, 1'b0);
    checks++; if (IN_READY !== 1'b0) begin errors++; $display("FAIL pp_full_rdy got %b want 0", IN_READY); end
    tick();
    checks++; if (CNT1 !== 2'd1 || OUT1 !== 1'b1) begin errors++; $display("FAIL pp_full_pop got cnt=%0d out=%b want cnt=1 out=1", CNT1, OUT1); end
    drive(1'b0, 2'b01, 1'b0); tick();
    checks++; if (CNT1 !== 2'd0) begin errors++; $display("FAIL pp_drain got %0d want 0", CNT1); end
  endtask

  task automatic test_isolation_wrap();
    logic [9:0] pat;
    pat = 10'b1011001110;
    READY0 = 1'b0; READY3 = 1'b1;
    drive(1'b1, 2'b00, 1'b1); tick();
    drive(1'b1, 2'b00, 1'b0); tick();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 2'b11, pat[i]);
      checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL iso_rdy word%0d got %b want 1", i, IN_READY); end
      tick();
      checks++; if (VALID3 !== 1'b1 || OUT3 !== pat[i] || CNT3 !== 2'd1) begin errors++; $display("FAIL iso_out word%0d got v=%b out=%b cnt=%0d want v=1 out=%b cnt=1", i, VALID3, OUT3, CNT3, pat[i]); end
      checks++; if (CNT0 !== 2'd2 || OUT0 !== 1'b1) begin errors++; $display("FAIL iso_ch0 word%0d got cnt=%0d out=%b want cnt=2 out=1", i, CNT0, OUT0); end
    end
    drive(1'b0, 2'b11, 1'b0); tick();
    checks++; if (VALID3 !== 1'b0) begin errors++; $display("FAIL iso_drain got %b want 0", VALID3); end
  endtask

  task automatic test_reset_mid();
    READY3 = 1'b0;
    drive(1'b1, 2'b11, 1'b1); tick();
    checks++; if (CNT0 !== 2'd2 || CNT3 !== 2'd1) begin errors++; $display("FAIL mid_pre got cnt0=%0d cnt3=%0d want 2 1", CNT0, CNT3); end
    RST = 1'b1; READY0 = 1'b1;
    drive(1'b1, 2'b00, 1'b1);
    checks++; if (IN_READY !== 1'b0) begin errors++; $display("FAIL mid_rdy got %b want 0", IN_READY); end
    tick();
    RST = 1'b0;
    drive(1'b0, 2'b00, 1'b0);
    checks++; if (vld !== 4'b0000) begin errors++; $display("FAIL mid_valid got %b want 0000", vld); end
    checks++; if ({CNT3, CNT2, CNT1, CNT0} !== 8'h00) begin errors++; $display("FAIL mid_cnt got %h want 00", {CNT3, CNT2, CNT1, CNT0}); end
    READY0 = 1'b0;
    drive(1'b1, 2'b00, 1'b1); tick();
    drive(1'b0, 2'b00, 1'b0);
    checks++; if (VALID0 !== 1'b1 || OUT0 !== 1'b1 || CNT0 !== 2'd1) begin errors++; $display("FAIL mid_fresh got v=%b out=%b cnt=%0d want v=1 out=1 cnt=1", VALID0, OUT0, CNT0); end
  endtask

  initial begin
    test_reset();
    test_routing();
    test_backpressure();
    test_simul_push_pop();
    test_isolation_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
